store_merge_rmw: RTL and testbench

Sub-word store unit for the MIPS datapath. It performs SB/SH/SW stores to a 32-bit word-only data memory that has no byte enables. SW is written directly. SB and SH use a read-modify-write sequence: read the word, merge the byte or halfword lanes, write the word back. It sits between the EX/MEM store path and the data RAM, and is the write-side counterpart of the load-path sign/zero extension.

---
 rtl/store_merge_rmw.sv | 148 ++++++++++++++
 tb/tb_store_merge_rmw.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_rmw.sv
// store_merge_rmw: sub-word store unit for a word-only data RAM.
// SW is written directly; SB/SH read the word, merge the addressed lane(s)
// (big-endian lane order) and write the word back.
//
// state | meaning
// IDLE  | ready for a request
// READ  | read strobe to RAM for the target word
// MERGE | RAM data valid, replace addressed lane(s)
// WRITE | write strobe, store complete (done)
// ERR   | rejected request (misaligned or illegal size)
module store_merge_rmw #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic              legal;
  logic              accept;

  assign accept = req_valid && (state == S_IDLE);

  // Alignment / size legality of the incoming request
  always_comb begin
    legal = 1'b0;
    case (req_size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~req_addr[0];
      SZ_WORD: legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal)                 state_nxt = S_ERR;
          else if (req_size == SZ_WORD) state_nxt = S_WRITE;
          else                        state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_MERGE;
      S_MERGE: state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes and pulses come from state only
  always_comb begin
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_READ:  mem_rd = 1'b1;
      S_WRITE: begin
        mem_wr = 1'b1;
        done   = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Lane replacement of the read word; untouched lanes pass through
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_HALF) begin
      if (lane_q[1]) merged[15:0]  = data_q[15:0];
      else           merged[31:16] = data_q[15:0];
    end else begin
      case (lane_q)
        2'b00:   merged[31:24] = data_q[7:0];
        2'b01:   merged[23:16] = data_q[7:0];
        2'b10:   merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end
  end

  // Request latch at acceptance and merge register capture in MERGE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        waddr_q <= req_addr[ADDR_W+1:2];
        lane_q  <= req_addr[1:0];
        size_q  <= req_size;
        data_q  <= req_data;
      end
      if (state == S_MERGE) merge_q <= merged;
    end
  end

  assign mem_addr  = waddr_q;
  assign mem_wdata = (size_q == SZ_WORD) ? data_q : merge_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed bench for store_merge_rmw with a small registered-read RAM model.
module tb_store_merge_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data = '0;
  logic        done;
  logic        err;
  logic [29:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:15];
  int n_checks = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int excl_cnt = 0;

  store_merge_rmw #(.ADDR_W(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // RAM: data valid the cycle after mem_rd, write at the edge ending mem_wr
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];
    if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
  end

  // Strobe activity counters, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
    if (mem_rd && mem_wr) excl_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one accept edge (unit assumed idle)
  task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_size  = size;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic word_store(input logic [31:0] addr, input logic [31:0] data);
    int rd0;
    rd0 = rd_cnt;
    issue(2'b10, addr, data);
    @(negedge clk);
    chk("sw_wr", {31'd0, mem_wr}, 32'd1);
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_addr", {2'b00, mem_addr}, addr >> 2);
    chk("sw_wdata", mem_wdata, data);
    chk("sw_ready_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("sw_ready_back", {31'd0, req_ready}, 32'd1);
    chk("sw_done_off", {31'd0, done}, 32'd0);
    chk("sw_no_rd", rd_cnt, rd0);
  endtask

  task automatic sub_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
    issue(size, addr, data);
    @(negedge clk);
    chk("rmw_rd", {31'd0, mem_rd}, 32'd1);
    chk("rmw_rd_addr", {2'b00, mem_addr}, addr >> 2);
    chk("rmw_no_wr_t1", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    chk("rmw_idle_t2", {30'd0, mem_rd, mem_wr}, 32'd0);
    @(negedge clk);
    chk("rmw_wr", {31'd0, mem_wr}, 32'd1);
    chk("rmw_done", {31'd0, done}, 32'd1);
    chk("rmw_wdata", mem_wdata, exp);
    chk("rmw_ready_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rmw_ready_back", {31'd0, req_ready}, 32'd1);
    chk("rmw_mem", mem[addr[5:2]], exp);
  endtask

  task automatic bad_req(input logic [1:0] size, input logic [31:0] addr);
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue(size, addr, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_ready_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("err_off", {31'd0, err}, 32'd0);
    chk("err_ready_back", {31'd0, req_ready}, 32'd1);
    chk("err_no_access", rd_cnt + wr_cnt, rd0 + wr0);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset values
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
    chk("rst_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    word_store(32'h0000_0010, 32'hDEAD_BEEF);

    mem[8] = 32'h1122_3344;
    sub_store(2'b00, 32'h0000_0021, 32'h0000_00AB, 32'h11AB_3344);
    mem[8] = 32'h1122_3344;
    sub_store(2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'h1122_CAFE);
    mem[8] = 32'h1122_3344;
    sub_store(2'b01, 32'h0000_0020, 32'h0000_CAFE, 32'hCAFE_3344);
    mem[8] = 32'h1122_3344;
    sub_store(2'b00, 32'h0000_0023, 32'h1234_5699, 32'h1122_3399);
    mem[8] = 32'h1122_3344;
    sub_store(2'b00, 32'h0000_0020, 32'h0000_00EE, 32'hEE22_3344);

    bad_req(2'b01, 32'h0000_0023);
    bad_req(2'b10, 32'h0000_0002);
    bad_req(2'b11, 32'h0000_0000);

    // Back-to-back: SB then SW held valid, inputs change while busy
    mem[12] = 32'hAABB_CCDD;
    req_valid = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h0000_0031;
    req_data = 32'h0000_0055;
    @(posedge clk);
    #1;
    req_size = 2'b10;
    req_addr = 32'h0000_0034;
    req_data = 32'h1234_5678;
    @(negedge clk);
    chk("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
    chk("b2b_rd_t1", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    chk("b2b_ready_t2", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_t3", {31'd0, req_ready}, 32'd0);
    chk("b2b_wdata1", mem_wdata, 32'hAA55_CCDD);
    chk("b2b_addr1", {2'b00, mem_addr}, 32'd12);
    @(negedge clk);
    chk("b2b_ready_t4", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wr2", {31'd0, mem_wr}, 32'd1);
    chk("b2b_addr2", {2'b00, mem_addr}, 32'd13);
    chk("b2b_wdata2", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("b2b_mem1", mem[12], 32'hAA55_CCDD);

    // Reset during MERGE of an SB
    mem[8] = 32'h1122_3344;
    issue(2'b00, 32'h0000_0021, 32'h0000_0077);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_strobes", {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
    chk("arst_addr", {2'b00, mem_addr}, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    wr0 = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_wr", wr_cnt, wr0);
    chk("arst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("arst_mem_intact", mem[8], 32'h1122_3344);

    chk("strobe_exclusive", excl_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
